// File: rtl/hamming_secded_pipeline.sv
// Three-stage Hamming(7,4)+overall-parity SEC/DED codec: encode, build the
// received word with injected data bits and classify it, then correct it.
module hamming_secded_pipeline (
    input  logic       reloj,
    input  logic       reset,
    input  logic [3:0] dato_entrada,
    input  logic [3:0] dato_error,
    output logic [7:0] palabra,
    output logic [7:0] recibido,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic       st,
    output logic       error_simple,
    output logic       error_doble,
    output logic [3:0] corregido,
    output logic [7:0] palabra_corregida,
    output logic       simplerror_detectado,
    output logic       doblerror_detectado,
    output logic       led_doblerror
);

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] w;
        w    = 8'h00;
        w[3] = d[0];
        w[5] = d[1];
        w[6] = d[2];
        w[7] = d[3];
        w[1] = d[0] ^ d[1] ^ d[3];
        w[2] = d[0] ^ d[2] ^ d[3];
        w[4] = d[1] ^ d[2] ^ d[3];
        w[0] = ^w[7:1];
        return w;
    endfunction

    function automatic logic [2:0] syndrome(input logic [7:0] r);
        logic [2:0] s;
        s[0] = r[1] ^ r[3] ^ r[5] ^ r[7];
        s[1] = r[2] ^ r[3] ^ r[6] ^ r[7];
        s[2] = r[4] ^ r[5] ^ r[6] ^ r[7];
        return s;
    endfunction

    logic [7:0] palabra_d, palabra_q;
    logic [3:0] err_d, err_q;
    logic [7:0] rec_d, rec_q;
    logic [2:0] syn_d, syn_q;
    logic       st_d, st_q;
    logic       simple_d, simple_q;
    logic       doble_d, doble_q;
    logic [7:0] corr_d, corr_q;
    logic       simple3_d, simple3_q;
    logic       doble3_d, doble3_q;
    logic       led_d, led_q;

    // Stage 1 next state: encode and keep the injection nibble aligned.
    always_comb begin
        palabra_d = encode(dato_entrada);
        err_d     = dato_error;
    end

    // Stage 2 next state: parity bits from the codeword, data bits from the injection nibble.
    always_comb begin
        rec_d    = {err_q[3:1], palabra_q[4], err_q[0], palabra_q[2:0]};
        syn_d    = syndrome(rec_d);
        st_d     = ^rec_d;
        simple_d = st_d;
        doble_d  = (st_d == 1'b0) && (syn_d != 3'd0);
    end

    // Stage 3 next state: a single error with S=0 lands on bit 0, i.e. p0.
    always_comb begin
        corr_d    = rec_q;
        simple3_d = simple_q;
        doble3_d  = doble_q;
        led_d     = led_q | doble_q;
        if (simple_q) begin
            corr_d = rec_q ^ (8'h01 << syn_q);
        end else begin
            corr_d = rec_q;
        end
    end

    // Pipeline registers with synchronous reset to the all-zero valid codeword.
    always_ff @(posedge reloj) begin
        if (reset) begin
            palabra_q <= 8'h00;
            err_q     <= 4'h0;
            rec_q     <= 8'h00;
            syn_q     <= 3'd0;
            st_q      <= 1'b0;
            simple_q  <= 1'b0;
            doble_q   <= 1'b0;
            corr_q    <= 8'h00;
            simple3_q <= 1'b0;
            doble3_q  <= 1'b0;
            led_q     <= 1'b0;
        end else begin
            palabra_q <= palabra_d;
            err_q     <= err_d;
            rec_q     <= rec_d;
            syn_q     <= syn_d;
            st_q      <= st_d;
            simple_q  <= simple_d;
            doble_q   <= doble_d;
            corr_q    <= corr_d;
            simple3_q <= simple3_d;
            doble3_q  <= doble3_d;
            led_q     <= led_d;
        end
    end

    assign palabra              = palabra_q;
    assign recibido             = rec_q;
    assign s1                   = syn_q[0];
    assign s2                   = syn_q[1];
    assign s3                   = syn_q[2];
    assign st                   = st_q;
    assign error_simple         = simple_q;
    assign error_doble          = doble_q;
    assign palabra_corregida    = corr_q;
    assign corregido            = {corr_q[7], corr_q[6], corr_q[5], corr_q[3]};
    assign simplerror_detectado = simple3_q;
    assign doblerror_detectado  = doble3_q;
    assign led_doblerror        = led_q;

endmodule

// File: tb/tb_hamming_secded_pipeline.sv
// Scoreboard bench for hamming_secded_pipeline: a reference model pushes the
// expected per-stage results when a nibble is driven; each stage is compared as it emerges.
module tb_hamming_secded_pipeline;

    logic       reloj;
    logic       reset;
    logic [3:0] dato_entrada;
    logic [3:0] dato_error;
    logic [7:0] palabra;
    logic [7:0] recibido;
    logic       s1, s2, s3, st;
    logic       error_simple, error_doble;
    logic [3:0] corregido;
    logic [7:0] palabra_corregida;
    logic       simplerror_detectado, doblerror_detectado, led_doblerror;

    hamming_secded_pipeline dut (
        .reloj                (reloj),
        .reset                (reset),
        .dato_entrada         (dato_entrada),
        .dato_error           (dato_error),
        .palabra              (palabra),
        .recibido             (recibido),
        .s1                   (s1),
        .s2                   (s2),
        .s3                   (s3),
        .st                   (st),
        .error_simple         (error_simple),
        .error_doble          (error_doble),
        .corregido            (corregido),
        .palabra_corregida    (palabra_corregida),
        .simplerror_detectado (simplerror_detectado),
        .doblerror_detectado  (doblerror_detectado),
        .led_doblerror        (led_doblerror)
    );

    typedef struct {
        logic [7:0] pal;
        logic [7:0] rec;
        logic [2:0] syn;
        logic       st;
        logic       sim;
        logic       dbl;
        logic [7:0] pc;
        logic [3:0] cor;
    } exp_t;

    exp_t q[$];
    int   n_tests;
    int   n_fail;
    logic led_exp;

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: syndrome is the XOR of the positions of all set bits.
    function automatic exp_t model(input logic [3:0] d, input logic [3:0] e);
        exp_t       x;
        logic [7:0] w;
        logic [2:0] pos;
        logic [2:0] acc;
        int         dpos [4];
        dpos = '{3, 5, 6, 7};
        w = 8'h00;
        acc = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w[dpos[i]] = d[i];
            if (d[i]) begin
                pos = 3'(dpos[i]);
                acc = acc ^ pos;
            end
        end
        w[1] = acc[0];
        w[2] = acc[1];
        w[4] = acc[2];
        w[0] = ^w[7:1];
        x.pal = w;
        x.rec = w;
        for (int i = 0; i < 4; i++) x.rec[dpos[i]] = e[i];
        x.syn = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x.rec[i]) begin
                pos = 3'(i);
                x.syn = x.syn ^ pos;
            end
        end
        x.st  = ^x.rec;
        x.sim = x.st;
        x.dbl = !x.st && (x.syn != 3'd0);
        x.pc  = x.rec;
        if (x.sim) x.pc[x.syn] = ~x.pc[x.syn];
        x.cor = {x.pc[7], x.pc[6], x.pc[5], x.pc[3]};
        return x;
    endfunction

    task automatic step(input logic [3:0] d, input logic [3:0] e);
        int   n;
        exp_t a;
        dato_entrada = d;
        dato_error   = e;
        q.push_back(model(d, e));
        @(posedge reloj);
        @(negedge reloj);
        n = q.size();
        a = q[n-1];
        check_eq("s1_palabra", {24'h0, palabra}, {24'h0, a.pal});
        if (n >= 2) begin
            a = q[n-2];
            check_eq("s2_recibido", {24'h0, recibido}, {24'h0, a.rec});
            check_eq("s2_syndrome", {29'h0, s3, s2, s1}, {29'h0, a.syn});
            check_eq("s2_st", {31'h0, st}, {31'h0, a.st});
            check_eq("s2_flags", {30'h0, error_simple, error_doble}, {30'h0, a.sim, a.dbl});
        end
        if (n >= 3) begin
            a = q.pop_front();
            led_exp = led_exp | a.dbl;
            check_eq("s3_pal_corr", {24'h0, palabra_corregida}, {24'h0, a.pc});
            check_eq("s3_corregido", {28'h0, corregido}, {28'h0, a.cor});
            check_eq("s3_flags", {30'h0, simplerror_detectado, doblerror_detectado},
                     {30'h0, a.sim, a.dbl});
            check_eq("s3_led", {31'h0, led_doblerror}, {31'h0, led_exp});
        end
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        dato_entrada = 4'h0;
        dato_error   = 4'h0;
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        q.delete();
        led_exp = 1'b0;
        check_eq("rst_words", {palabra, recibido, palabra_corregida, corregido, 4'h0},
                 32'h0);
        check_eq("rst_bits", {20'h0, s1, s2, s3, st, error_simple, error_doble,
                 simplerror_detectado, doblerror_detectado, led_doblerror, 3'b000}, 32'h0);
        reset = 1'b0;
    endtask

    // One case followed by two idle nibbles, checking literal values per stage.
    task automatic isolated(input logic [3:0] d, input logic [3:0] e,
                            input logic [7:0] pal, input logic [7:0] rec,
                            input logic [2:0] syn, input logic [7:0] pc);
        step(d, e);
        check_eq("lit_palabra", {24'h0, palabra}, {24'h0, pal});
        step(4'h0, 4'h0);
        check_eq("lit_recibido", {24'h0, recibido}, {24'h0, rec});
        check_eq("lit_syndrome", {29'h0, s3, s2, s1}, {29'h0, syn});
        step(4'h0, 4'h0);
        check_eq("lit_pal_corr", {24'h0, palabra_corregida}, {24'h0, pc});
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        led_exp      = 1'b0;
        reset        = 1'b1;
        dato_entrada = 4'h0;
        dato_error   = 4'h0;
        do_reset();

        step(4'h0, 4'h0);
        isolated(4'b1010, 4'b1010, 8'hA5, 8'hA5, 3'd0, 8'hA5);
        isolated(4'b0010, 4'b0000, 8'h33, 8'h13, 3'd5, 8'h33);
        isolated(4'b1101, 4'b1011, 8'hCC, 8'hAC, 3'd3, 8'hAC);

        step(4'b1010, 4'b1010);
        step(4'h0, 4'h0);
        step(4'h0, 4'h0);
        check_eq("sticky_dbl_clear", {31'h0, doblerror_detectado}, 32'h0);
        check_eq("sticky_led_held", {31'h0, led_doblerror}, 32'h1);
        do_reset();
        check_eq("led_after_reset", {31'h0, led_doblerror}, 32'h0);

        step(4'b1010, 4'b1010);
        step(4'b0010, 4'b0000);
        step(4'b1101, 4'b1011);
        step(4'h0, 4'h0);
        step(4'h0, 4'h0);

        for (int i = 0; i < 60; i++) begin
            if (i == 30) do_reset();
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        step(4'h0, 4'h0);
        step(4'h0, 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
